// File: rtl/count_uart_pkg.sv
// rtl/count_uart_pkg.sv - shared types and constants for the counter UART transmitter
package count_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing end-of-bit and one-before-end strobes
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    assign tick     = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - UART transmitter for counter values, optional even parity
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    import count_uart_pkg::*;

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       parity;
    logic       tick;
    logic       pre_tick;
    logic       accept;
    logic       restart;

    assign accept  = (state == IDLE) && in_valid && in_ready;
    // Every state change restarts the bit period so each state lasts exactly one bit.
    assign restart = accept || ((state != IDLE) && tick);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            parity     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        shreg    <= in_data;
                        parity   <= ^in_data;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the last stop cycle.
                    if (pre_tick) begin
                        frame_done <= 1'b1;
                    end
                    if (tick) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
